// File: rtl/div3_frame_tx.sv
// div3_frame_tx: serial frame transmitter for a divide-by-3 residue checker.
// Shifts a WIDTH-bit payload out MSB-first and then appends 2 check bits.
// The check bits make the whole (WIDTH+2)-bit frame, read as an unsigned
// MSB-first integer, an exact multiple of 3.
//
// Optional feature: define DIV3_TX_INJECT_EN to add the 'inject' input. When
// 'inject' is high on the accept edge, check[0] of that frame is inverted. This
// deliberately produces a frame that is not a multiple of 3.
//
// Handshake: a frame is accepted on a rising edge where start==1 and busy==0.
// din (and inject) are sampled on that edge only. start is ignored while busy==1.
// busy falls one cycle after the last check bit, so back-to-back frames are
// separated by exactly one idle cycle.
module div3_frame_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
`ifdef DIV3_TX_INJECT_EN
  input  logic             inject,
`endif
  output logic             busy,
  output logic             dout,
  output logic             dvalid,
  output logic             last,
  output logic [1:0]       check,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-2:0] sr;      // payload bits not yet placed on dout
  logic [CW-1:0]    cnt;     // bit index inside DATA, check index inside CHK
  logic [1:0]       r;       // payload residue mod 3 of the bits already sent
  logic             inj_q;   // inject captured at accept
  logic [1:0]       r_next;
  logic [1:0]       new_check;

  // Residue after appending one bit: (2r + b) mod 3. The code 2'b11 is illegal
  // and collapses to 0.
  function automatic logic [1:0] r_step(input logic [1:0] rr, input logic b);
    case (rr)
      2'd0:    r_step = b ? 2'd1 : 2'd0;
      2'd1:    r_step = b ? 2'd0 : 2'd2;
      2'd2:    r_step = b ? 2'd2 : 2'd1;
      default: r_step = 2'd0;
    endcase
  endfunction

  // Check value (3 - r) mod 3. This works because frame = payload*4 + check
  // and 4 is congruent to 1 mod 3.
  function automatic logic [1:0] chk_of(input logic [1:0] rr);
    case (rr)
      2'd1:    chk_of = 2'd2;
      2'd2:    chk_of = 2'd1;
      default: chk_of = 2'd0;
    endcase
  endfunction

  // Fold the payload bit currently on dout into the residue, and derive the check bits from it.
  always_comb begin
    r_next    = r_step(r, dout);
    new_check = chk_of(r_next) ^ {1'b0, inj_q};
  end

  assign state_dbg = state;

  // Frame sequencer. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      r      <= 2'd0;
      inj_q  <= 1'b0;
      busy   <= 1'b0;
      dout   <= 1'b0;
      dvalid <= 1'b0;
      last   <= 1'b0;
      check  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          busy   <= 1'b0;
          dout   <= 1'b0;
          dvalid <= 1'b0;
          last   <= 1'b0;
          if (start) begin
            state  <= DATA;
            busy   <= 1'b1;
            dvalid <= 1'b1;
            dout   <= din[WIDTH-1];
            sr     <= din[WIDTH-2:0];
            cnt    <= '0;
            r      <= 2'd0;
`ifdef DIV3_TX_INJECT_EN
            inj_q  <= inject;
`else
            inj_q  <= 1'b0;
`endif
          end
        end
        DATA: begin
          r <= r_next;
          if (cnt == CW'(WIDTH - 1)) begin
            check <= new_check;
            dout  <= new_check[1];
            cnt   <= '0;
            state <= CHK;
          end else begin
            dout <= sr[WIDTH-2];
            sr   <= sr << 1;
            cnt  <= cnt + CW'(1);
          end
        end
        CHK: begin
          if (cnt == '0) begin
            dout <= check[0];
            last <= 1'b1;
            cnt  <= CW'(1);
          end else begin
            dout   <= 1'b0;
            dvalid <= 1'b0;
            last   <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          sr     <= '0;
          cnt    <= '0;
          r      <= 2'd0;
          inj_q  <= 1'b0;
          busy   <= 1'b0;
          dout   <= 1'b0;
          dvalid <= 1'b0;
          last   <= 1'b0;
          check  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div3_frame_tx.sv
// tb_div3_frame_tx: bench for div3_frame_tx with WIDTH=8.
// Covers the reset state, a table of known frames, continuous start, a reset
// during a frame, and random payloads. The random payloads are checked against
// an arithmetic frame model. Define DIV3_TX_INJECT_EN to also exercise inject.
module tb_div3_frame_tx;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic [W-1:0] din;
  logic         inject;
  logic         busy;
  logic         dout;
  logic         dvalid;
  logic         last;
  logic [1:0]   check;
  logic [1:0]   state_dbg;

  div3_frame_tx #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .din      (din),
`ifdef DIV3_TX_INJECT_EN
    .inject   (inject),
`endif
    .busy     (busy),
    .dout     (dout),
    .dvalid   (dvalid),
    .last     (last),
    .check    (check),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W+1:0] exp_q[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame value from the arithmetic rule: payload*4 + check, where
  // check = (3 - payload mod 3) mod 3, with bit 0 flipped when inject is set.
  function automatic logic [W+1:0] model_frame(input logic [W-1:0] d, input logic inj);
    int c;
    c = (3 - (int'(d) % 3)) % 3;
    if (inj) c = c ^ 1;
    return (W+2)'(int'(d) * 4 + c);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at a negedge with busy low, or records a timeout.
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Sends one frame and collects it from the serial outputs.
  task automatic run_frame(input logic [W-1:0] d, input logic inj,
                           output logic [W+1:0] frame, output logic [1:0] chk,
                           output logic ok);
    wait_idle();
    start  = 1'b1;
    din    = d;
    inject = inj;
    @(negedge clk);
    start  = 1'b0;
    inject = 1'b0;
    din    = W'($urandom);
    frame  = '0;
    ok     = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      if (dvalid !== 1'b1 || busy !== 1'b1 || last !== (i == W + 1)) ok = 1'b0;
      frame = {frame[W:0], dout};
      @(negedge clk);
    end
    if (dvalid !== 1'b0 || busy !== 1'b0 || dout !== 1'b0 || last !== 1'b0) ok = 1'b0;
    chk = check;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] din;
    logic [1:0]   exp_check;
    logic [W+1:0] exp_frame;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W+1:0] fr;
    logic [1:0]   ck;
    logic         ok;
    logic         flag;
    logic [W+1:0] acc;
    logic [W-1:0] d;
    int           p;

    vecs[0] = '{8'hFF, 2'b00, 10'd1020};
    vecs[1] = '{8'h05, 2'b01, 10'd21};
    vecs[2] = '{8'h00, 2'b00, 10'd0};
    vecs[3] = '{8'h01, 2'b10, 10'd6};
    vecs[4] = '{8'h80, 2'b01, 10'd513};
    vecs[5] = '{8'hAA, 2'b01, 10'd681};
    vecs[6] = '{8'h02, 2'b01, 10'd9};
    vecs[7] = '{8'h07, 2'b10, 10'd30};

    // Reset state
    rst = 1'b1; start = 1'b0; din = '0; inject = 1'b0;
    repeat (2) @(negedge clk);
    cmp("rst_busy", busy, 0);
    cmp("rst_dvalid", dvalid, 0);
    cmp("rst_dout", dout, 0);
    cmp("rst_last", last, 0);
    cmp("rst_check", check, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven known frames
    foreach (vecs[i]) begin
      run_frame(vecs[i].din, 1'b0, fr, ck, ok);
      cmp("tbl_frame", fr, vecs[i].exp_frame);
      cmp("tbl_check", ck, vecs[i].exp_check);
      cmp("tbl_proto", ok, 1);
      cmp("tbl_rem", fr % 3, 0);
    end

    // start held high: frames every W+3 cycles, din sampled only at accept
    wait_idle();
    flag = 1'b1;
    acc  = '0;
    for (int c = 0; c <= 3 * (W + 3); c++) begin
      if (c >= 1) begin
        p = (c - 1) % (W + 3);
        if (p == 0) acc = '0;
        if (p < W + 2) begin
          if (dvalid !== 1'b1 || busy !== 1'b1 || last !== (p == W + 1)) flag = 1'b0;
          acc = {acc[W:0], dout};
          if (p == W + 1) begin
            if (exp_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL cont_queue: no expected frame, got %0d", acc);
            end else begin
              cmp("cont_frame", acc, exp_q.pop_front());
            end
          end
        end else begin
          if (dvalid !== 1'b0 || busy !== 1'b0) flag = 1'b0;
        end
      end
      start = (c < 3 * (W + 3));
      din   = W'($urandom);
      if (c % (W + 3) == 0 && c < 3 * (W + 3)) exp_q.push_back(model_frame(din, 1'b0));
      @(negedge clk);
    end
    start = 1'b0;
    cmp("cont_proto", flag, 1);

    // Reset in the middle of the payload aborts the frame
    wait_idle();
    start = 1'b1; din = 8'hC3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("abort_busy", busy, 0);
    cmp("abort_dvalid", dvalid, 0);
    cmp("abort_dout", dout, 0);
    cmp("abort_check", check, 0);
    flag = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (dvalid !== 1'b0 || busy !== 1'b0) flag = 1'b0;
    end
    cmp("abort_no_resume", flag, 1);
    run_frame(8'h07, 1'b0, fr, ck, ok);
    cmp("post_abort_frame", fr, 30);
    cmp("post_abort_proto", ok, 1);

    // Random payloads checked against the arithmetic model and a residue checker
    flag = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d = W'($urandom_range(0, 255));
      exp_q.push_back(model_frame(d, 1'b0));
      run_frame(d, 1'b0, fr, ck, ok);
      cmp("rand_frame", fr, exp_q.pop_front());
      cmp("rand_rem", fr % 3, 0);
      if (!ok) flag = 1'b0;
    end
    cmp("rand_proto", flag, 1);

`ifdef DIV3_TX_INJECT_EN
    // inject at accept corrupts check[0] of that frame only
    run_frame(8'h07, 1'b1, fr, ck, ok);
    cmp("inj_frame", fr, model_frame(8'h07, 1'b1));
    cmp("inj_check", ck, 3);
    cmp("inj_rem", fr % 3, 1);
    run_frame(8'h07, 1'b0, fr, ck, ok);
    cmp("inj_next_frame", fr, 30);
    cmp("inj_next_check", ck, 2);
    // inject raised after the accept edge has no effect
    wait_idle();
    start = 1'b1; din = 8'h05; inject = 1'b0;
    @(negedge clk);
    start = 1'b0; inject = 1'b1;
    repeat (W + 2) @(negedge clk);
    inject = 1'b0;
    cmp("inj_late_check", check, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
